// File: rtl/operand_skid_buffer_pkg.sv
// Shared packing of the {sel, ina, inb} operand bundle; the issue logic packs bundles the same way.
package operand_skid_buffer_pkg;

  function automatic int payload_w(input int width);
    return 1 + 2 * width;
  endfunction

  // sel sits above both operands; ina above inb.
  function automatic int sel_pos(input int width);
    return 2 * width;
  endfunction

  function automatic int ina_lo(input int width);
    return width;
  endfunction

  localparam int INB_LO = 0;

endpackage

// File: rtl/operand_skid_buffer.sv
// Registered valid/ready stage in front of the 2:1 operand mux, with a main and a skid entry
// so that full throughput is kept while in_ready comes straight from a flop.
module operand_skid_buffer
  import operand_skid_buffer_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_ina,
  input  logic [WIDTH-1:0] in_inb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sel,
  output logic [WIDTH-1:0] out_ina,
  output logic [WIDTH-1:0] out_inb,
  output logic [1:0]       occupancy
);

  localparam int PW  = payload_w(WIDTH);
  localparam int SEL = sel_pos(WIDTH);
  localparam int INA = ina_lo(WIDTH);

  logic [PW-1:0] in_pld;
  logic [PW-1:0] main_nxt;
  logic [PW-1:0] main_pld_p1;
  logic [PW-1:0] skid_pld_p1;
  logic          main_vld_p1;
  logic          skid_vld_p1;
  logic          in_ready_p1;
  logic [1:0]    occ_p1;

  logic          accept;
  logic          main_open;
  logic          main_load;
  logic          skid_load;
  logic          main_vld_nxt;
  logic          skid_vld_nxt;
  logic [1:0]    occ_nxt;

  always_comb begin
    in_pld                  = '0;
    in_pld[SEL]             = in_sel;
    in_pld[INA +: WIDTH]    = in_ina;
    in_pld[INB_LO +: WIDTH] = in_inb;
  end

  // Main is free to load when it is empty or being popped this edge; the skid
  // entry always drains into main before a new input is allowed to.
  always_comb begin
    accept       = in_valid & in_ready_p1;
    main_open    = ~main_vld_p1 | out_ready;
    main_load    = main_open & (skid_vld_p1 | accept);
    skid_load    = accept & (~main_open | skid_vld_p1);
    main_nxt     = skid_vld_p1 ? skid_pld_p1 : in_pld;
    main_vld_nxt = main_open ? (skid_vld_p1 | accept) : 1'b1;
    skid_vld_nxt = main_open ? (skid_vld_p1 & accept) : (skid_vld_p1 | accept);
    occ_nxt      = {1'b0, main_vld_nxt} + {1'b0, skid_vld_nxt};
  end

  // p1: main/skid entries and registered handshake/occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_ready_p1 <= 1'b1;
      occ_p1      <= 2'd0;
      main_pld_p1 <= '0;
      skid_pld_p1 <= '0;
    end else if (flush) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_ready_p1 <= 1'b1;
      occ_p1      <= 2'd0;
    end else begin
      main_vld_p1 <= main_vld_nxt;
      skid_vld_p1 <= skid_vld_nxt;
      in_ready_p1 <= ~skid_vld_nxt;
      occ_p1      <= occ_nxt;
      if (main_load) main_pld_p1 <= main_nxt;
      if (skid_load) skid_pld_p1 <= in_pld;
    end
  end

  assign in_ready  = in_ready_p1;
  assign out_valid = main_vld_p1;
  assign out_sel   = main_pld_p1[SEL];
  assign out_ina   = main_pld_p1[INA +: WIDTH];
  assign out_inb   = main_pld_p1[INB_LO +: WIDTH];
  assign occupancy = occ_p1;

endmodule
